sin_generator: RTL and testbench
================================

// Module: sin_generator
// PURPOSE
//   Free-running digital sine source for the BPSK modulator: one sample per enabled clock.
//   Samples come from a lookup table covering exactly one period.
//   Drives the sine and its negation in parallel so the BPSK mapper selects phase 0/180 by mux.
//   Also exposes the sample index for phase alignment of downstream symbol timing.
// PARAMETERS
//   SAMPLE_NUMBER  256  samples per sine period; power of two, >= 8
//   SAMPLE_WIDTH   12   bits per sample, two's complement signed
//   CNT_WIDTH      $clog2(SAMPLE_NUMBER) (derived localparam, 8 by default)
// PORTS
//   clk          in   1             system clock, all state on rising edge
//   arstn        in   1             asynchronous active-low reset
//   en           in   1             sample-advance enable, active high
//   sin_out      out  SAMPLE_WIDTH  current sine sample, signed
//   neg_sin_out  out  SAMPLE_WIDTH  arithmetic negation of sin_out, signed
//   cnt_out      out  CNT_WIDTH     table index of the sample now on sin_out
// BEHAVIOUR
//   - One clock, clk; reset arstn is asynchronous, active-low.
//   - Table: LUT[k] = round(A*sin(2*pi*k/SAMPLE_NUMBER)), A = 2^(SAMPLE_WIDTH-1)-1 (2047 default);
//     round half away from zero. Peak is A, never -2^(SAMPLE_WIDTH-1), so negation never overflows.
//   - Table may be a full-period ROM or a quarter-wave table plus symmetry folding;
//     output values must be identical to the formula either way.
//   - Internal phase counter ph (CNT_WIDTH bits).
//   - arstn low (async, immediate): ph=0, sin_out=0, neg_sin_out=0, cnt_out=0; held while low.
//   - Rising clk with en=1: sin_out<=LUT[ph], neg_sin_out<=-LUT[ph], cnt_out<=ph, ph<=ph+1.
//   - Rising clk with en=0: all state and outputs hold.
//   - Latency: sin_out, neg_sin_out and cnt_out update on the same edge and always refer to the
//     same index: sin_out == LUT[cnt_out] and neg_sin_out == -sin_out at all times after first en edge.
//   - Wrap: ph rolls SAMPLE_NUMBER-1 -> 0 with no gap or repeat; period is exactly SAMPLE_NUMBER
//     enabled clocks.
//   - Reset released: first enabled edge outputs index 0 (sin_out=0, cnt_out=0).
//   - Reset mid-period: outputs clear at once; restart from index 0 on next enabled edge.
//   - en toggling: phase resumes exactly where it stopped; no sample is skipped.
//   - Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//   1. Reset: arstn=0 with en=1 and clk running -> sin_out=0, neg_sin_out=0, cnt_out=0 throughout.
//   2. Release arstn, en=1: successive edges give cnt_out 0,1,2,... and sin_out 0,50,100,...;
//      cnt_out=64 -> 2047, 128 -> 0, 192 -> -2047 (12'h801), 255 -> -50.
//   3. Run 600 enabled clocks: cnt_out wraps 255->0, sin_out at 256k+i equals sin_out at i;
//      neg_sin_out == -sin_out on every cycle.
//   4. Hold en=0 for 10 clocks at cnt_out=37 -> all outputs frozen; re-enable -> next cnt_out=38.
//   5. Assert arstn between clock edges at cnt_out=100 -> outputs zero immediately (no clk edge);
//      release -> sequence restarts at index 0.
//   6. Self-check full table: compare each sin_out against formula with real math; max error 0,
//      quarter-wave symmetry LUT[k] == LUT[128-k] == -LUT[128+k] holds.

Source files
------------

// File: rtl/sin_generator.sv
// rtl/sin_generator.sv - free-running sine/negated-sine source with phase index
// Quarter-wave table with symmetry folding; outputs registered together each enabled clock.
module sin_generator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12
) (
  input  logic                                   clk,
  input  logic                                   arstn,
  input  logic                                   en,
  output logic signed [SAMPLE_WIDTH-1:0]         sin_out,
  output logic signed [SAMPLE_WIDTH-1:0]         neg_sin_out,
  output logic        [$clog2(SAMPLE_NUMBER)-1:0] cnt_out
);

  localparam int CNT_WIDTH = $clog2(SAMPLE_NUMBER);
  localparam int QUARTER   = SAMPLE_NUMBER / 4;
  localparam int QIDX_W    = CNT_WIDTH - 1;
  localparam int AMPLITUDE = (1 << (SAMPLE_WIDTH - 1)) - 1;
  localparam real PI       = 3.14159265358979323846;

  // First-quadrant values are non-negative, so +0.5 then truncate is round-half-away.
  function automatic logic [SAMPLE_WIDTH-1:0] quarter_value(input int k);
    real y;
    y = real'(AMPLITUDE) * $sin(2.0 * PI * real'(k) / real'(SAMPLE_NUMBER));
    return SAMPLE_WIDTH'($rtoi(y + 0.5));
  endfunction

  logic [SAMPLE_WIDTH-1:0] quarter_rom [0:QUARTER];

  for (genvar k = 0; k <= QUARTER; k++) begin : g_rom
    localparam logic [SAMPLE_WIDTH-1:0] ROM_VAL = quarter_value(k);
    assign quarter_rom[k] = ROM_VAL;
  end

  logic        [CNT_WIDTH-1:0]    ph;
  logic        [QIDX_W-1:0]       fold_idx;
  logic        [QIDX_W-1:0]       rom_idx;
  logic signed [SAMPLE_WIDTH-1:0] rom_mag;
  logic signed [SAMPLE_WIDTH-1:0] lut_val;

  // Odd quadrants read the table backwards; the second half of the period is negated.
  always_comb begin
    fold_idx = {1'b0, ph[CNT_WIDTH-3:0]};
    rom_idx  = fold_idx;
    if (ph[CNT_WIDTH-2]) begin
      rom_idx = QIDX_W'(QUARTER) - fold_idx;
    end
    rom_mag = $signed(quarter_rom[rom_idx]);
    lut_val = ph[CNT_WIDTH-1] ? -rom_mag : rom_mag;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ph          <= '0;
      sin_out     <= '0;
      neg_sin_out <= '0;
      cnt_out     <= '0;
    end else if (en) begin
      sin_out     <= lut_val;
      neg_sin_out <= -lut_val;
      cnt_out     <= ph;
      ph          <= ph + 1'b1;
    end
  end

endmodule

// File: tb/tb_sin_generator.sv
// tb/tb_sin_generator.sv - directed self-checking bench for sin_generator
// Hand constants plus a real-math reference table for the full period.
module tb_sin_generator;

  logic               clk;
  logic               arstn;
  logic               en;
  logic signed [11:0] sin_out;
  logic signed [11:0] neg_sin_out;
  logic        [7:0]  cnt_out;

  int n_checks;
  int n_fails;
  int first_period [0:255];
  int ref_lut      [0:255];

  sin_generator #(.SAMPLE_NUMBER(256), .SAMPLE_WIDTH(12)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .en          (en),
    .sin_out     (sin_out),
    .neg_sin_out (neg_sin_out),
    .cnt_out     (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int k);
    real y;
    y = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0);
    if (y >= 0.0) return $rtoi(y + 0.5);
    return -$rtoi(-y + 0.5);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_sin"}, sin_out, 0);
    chk({tag, "_neg"}, neg_sin_out, 0);
    chk({tag, "_cnt"}, cnt_out, 0);
  endtask

  task automatic advance_to(input int target, input string tag);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge clk); #1;
      if (cnt_out == 8'(target)) found = 1'b1;
    end
    chk(tag, int'(found), 1);
  endtask

  initial begin
    int frozen_sin;
    n_checks = 0;
    n_fails  = 0;
    for (int k = 0; k < 256; k++) ref_lut[k] = model(k);

    // Reset held with en high and clock running.
    arstn = 1'b0;
    en    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_zero("reset");
    end

    // Release and run 600 enabled clocks.
    arstn = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      chk("run_cnt", cnt_out, i % 256);
      chk("run_neg", neg_sin_out, -int'(sin_out));
      if (i < 256) begin
        first_period[i] = sin_out;
        chk("table_formula", sin_out, ref_lut[i]);
      end else begin
        chk("wrap_repeat", sin_out, first_period[i % 256]);
      end
      case (i)
        1:   chk("idx1", sin_out, 50);
        2:   chk("idx2", sin_out, 100);
        64:  chk("idx64", sin_out, 2047);
        128: chk("idx128", sin_out, 0);
        192: chk("idx192_hex", int'(sin_out[11:0]), 'h801);
        255: chk("idx255", sin_out, -50);
        256: chk("wrap_cnt0", cnt_out, 0);
        default: ;
      endcase
    end

    // Quarter-wave symmetry of the captured table.
    for (int k = 0; k <= 64; k++) begin
      chk("sym_mirror", first_period[k], first_period[128 - k]);
      chk("sym_negate", first_period[k], -first_period[(128 + k) % 256]);
    end

    // Enable hold at index 37.
    advance_to(37, "reach37");
    @(negedge clk);
    en = 1'b0;
    frozen_sin = sin_out;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_cnt", cnt_out, 37);
      chk("hold_sin", sin_out, frozen_sin);
      chk("hold_neg", neg_sin_out, -frozen_sin);
    end
    en = 1'b1;
    @(posedge clk); #1;
    chk("resume_cnt", cnt_out, 38);
    chk("resume_sin", sin_out, ref_lut[38]);

    // Asynchronous reset between edges at index 100.
    advance_to(100, "reach100");
    chk("pre_reset_sin", sin_out, ref_lut[100]);
    #2;
    arstn = 1'b0;
    #1;
    check_zero("async");
    @(negedge clk);
    check_zero("async_hold");
    arstn = 1'b1;
    @(posedge clk); #1;
    chk("restart_cnt0", cnt_out, 0);
    chk("restart_sin0", sin_out, 0);
    @(posedge clk); #1;
    chk("restart_cnt1", cnt_out, 1);
    chk("restart_sin1", sin_out, 50);
    chk("restart_neg1", neg_sin_out, -50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
